// File: rtl/quad_encoder_if.sv
// quad_encoder_if: encoder line inputs, control levels and position/status outputs of the encoder front end
interface quad_encoder_if #(parameter int CNT_W = 32);
  logic enc_a, enc_b, enc_z, clear_pos, index_clear_en, err_clear;
  logic [CNT_W-1:0] actual_pos;
  logic dir, step_pulse, index_seen, err_illegal;
  logic [7:0] illegal_cnt;
  modport master (output enc_a, enc_b, enc_z, clear_pos, index_clear_en, err_clear,
                  input actual_pos, dir, step_pulse, index_seen, err_illegal, illegal_cnt);
  modport slave (input enc_a, enc_b, enc_z, clear_pos, index_clear_en, err_clear,
                 output actual_pos, dir, step_pulse, index_seen, err_illegal, illegal_cnt);
endinterface

// File: rtl/quad_encoder_counter.sv
// quad_encoder_counter: synchronises and filters A/B/Z, x4-decodes A/B into a signed position, flags illegal steps
module quad_encoder_counter #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  quad_encoder_if.slave bus
);
  logic [2:0] raw, s1, s2, filt;
  logic [3:0] cnt [3];
  logic [1:0] ab, prev;
  logic [4:0] init_cnt;
  logic init, z_q, fwd, rev, ill, z_rise;
  assign raw = {bus.enc_z, bus.enc_a, bus.enc_b};
  assign ab = filt[1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      filt <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++)
        if (s2[i] == filt[i]) cnt[i] <= '0;
        else if (cnt[i] == 4'(FILTER_LEN - 1)) begin
          filt[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 4'd1;
    end
  end
  // Gray-code successor/predecessor tests; during init prev just tracks filt
  always_comb begin
    fwd = !init && ab == {~prev[0], prev[1]};
    rev = !init && ab == {prev[0], ~prev[1]};
    ill = !init && ab == ~prev;
    z_rise = filt[2] & ~z_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      init <= 1'b1;
      init_cnt <= '0;
      prev <= '0;
      z_q <= 1'b0;
      bus.actual_pos <= '0;
      bus.dir <= 1'b0;
      bus.step_pulse <= 1'b0;
      bus.index_seen <= 1'b0;
      bus.err_illegal <= 1'b0;
      bus.illegal_cnt <= '0;
    end else begin
      if (init) begin
        init_cnt <= init_cnt + 5'd1;
        init <= init_cnt != 5'(FILTER_LEN + 1);
      end
      prev <= ab;
      z_q <= filt[2];
      bus.step_pulse <= fwd | rev;
      bus.dir <= (fwd | rev) ? fwd : bus.dir;
      bus.actual_pos <= (bus.clear_pos || (bus.index_clear_en && z_rise)) ? '0 :
                        fwd ? bus.actual_pos + CNT_W'(1) :
                        rev ? bus.actual_pos - CNT_W'(1) : bus.actual_pos;
      bus.index_seen <= bus.index_seen | z_rise;
      bus.err_illegal <= ill | (bus.err_illegal & ~bus.err_clear);
      bus.illegal_cnt <= ill ? (bus.err_clear ? 8'd1 : (&bus.illegal_cnt) ? bus.illegal_cnt : bus.illegal_cnt + 8'd1) :
                         bus.err_clear ? 8'd0 : bus.illegal_cnt;
    end
  end
endmodule

// File: tb/tb_quad_encoder_counter.sv
// tb_quad_encoder_counter: directed sequence with a step scoreboard for quad_encoder_counter
module tb_quad_encoder_counter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  quad_encoder_if enc ();
  quad_encoder_counter dut (.clk(clk), .reset(reset), .bus(enc));
  typedef struct packed {logic [31:0] pos; logic dir;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, pulses = 0;
  logic [31:0] exp_pos;
  logic [1:0] ab;
  localparam logic [1:0] FWD_SEQ [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:0] REV_SEQ [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] nxt(input bit forward, input logic [1:0] c);
    nxt = 2'b00;
    for (int j = 0; j < 4; j++)
      if (forward ? FWD_SEQ[(j + 3) % 4] == c : REV_SEQ[(j + 3) % 4] == c)
        nxt = forward ? FWD_SEQ[j] : REV_SEQ[j];
  endfunction

  task automatic drive_ab(input logic [1:0] v, input int hold);
    enc.enc_a = v[1];
    enc.enc_b = v[0];
    ab = v;
    repeat (hold) @(negedge clk);
  endtask

  task automatic step(input bit forward, input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      logic [1:0] nx;
      nx = nxt(forward, ab);
      exp_pos = enc.clear_pos ? 32'd0 : forward ? exp_pos + 32'd1 : exp_pos - 32'd1;
      q.push_back(exp_t'{exp_pos, forward});
      drive_ab(nx, hold);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pos"}, enc.actual_pos, 0);
    chk({tag, "_dir"}, 32'(enc.dir), 0);
    chk({tag, "_step"}, 32'(enc.step_pulse), 0);
    chk({tag, "_idx"}, 32'(enc.index_seen), 0);
    chk({tag, "_err"}, 32'(enc.err_illegal), 0);
    chk({tag, "_cnt"}, 32'(enc.illegal_cnt), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && enc.step_pulse === 1'b1) begin
      pulses++;
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_step observed pos=%0h expected no step", enc.actual_pos);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("step_pos", enc.actual_pos, e.pos);
        chk("step_dir", 32'(enc.dir), 32'(e.dir));
      end
    end
  end

  initial begin
    reset = 1'b1;
    enc.enc_a = 0; enc.enc_b = 0; enc.enc_z = 0;
    enc.clear_pos = 0; enc.index_clear_en = 0; enc.err_clear = 0;
    ab = 2'b00;
    exp_pos = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    step(1, 32, 20);
    chk("fwd32_pos", enc.actual_pos, 32);
    chk("fwd32_dir", 32'(enc.dir), 1);
    chk("fwd32_pulses", pulses, 32);
    chk("fwd32_err", 32'(enc.err_illegal), 0);
    step(0, 32, 20);
    chk("rev32_pos", enc.actual_pos, 0);
    chk("rev32_dir", 32'(enc.dir), 0);
    // A rises: first sampled at edge e, count must move exactly at e+6
    enc.enc_a = 1'b1;
    ab = 2'b10;
    exp_pos = 1;
    q.push_back(exp_t'{32'd1, 1'b1});
    repeat (6) @(negedge clk);
    chk("lat_e5_pos", enc.actual_pos, 0);
    @(negedge clk);
    chk("lat_e6_pos", enc.actual_pos, 1);
    chk("lat_e6_step", 32'(enc.step_pulse), 1);
    repeat (10) @(negedge clk);
    enc.enc_b = 1'b1;
    repeat (3) @(negedge clk);
    enc.enc_b = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_pos", enc.actual_pos, 1);
    chk("glitch_pulses", pulses, 65);
    step(0, 1, 20);
    force enc.actual_pos = 32'h7FFF_FFFF;
    #1;
    release enc.actual_pos;
    exp_pos = 32'h7FFF_FFFF;
    @(negedge clk);
    step(1, 1, 20);
    chk("wrap_up", enc.actual_pos, 32'h8000_0000);
    enc.clear_pos = 1'b1;
    @(negedge clk);
    enc.clear_pos = 1'b0;
    exp_pos = 0;
    chk("clear_pulse", enc.actual_pos, 0);
    step(0, 1, 20);
    chk("wrap_down", enc.actual_pos, 32'hFFFF_FFFF);
    drive_ab(2'b11, 20);
    chk("ill1_err", 32'(enc.err_illegal), 1);
    chk("ill1_cnt", 32'(enc.illegal_cnt), 1);
    chk("ill1_pos", enc.actual_pos, 32'hFFFF_FFFF);
    for (int i = 0; i < 299; i++) drive_ab(~ab, 8);
    chk("ill300_cnt", 32'(enc.illegal_cnt), 255);
    chk("ill300_err", 32'(enc.err_illegal), 1);
    chk("ill300_pos", enc.actual_pos, 32'hFFFF_FFFF);
    enc.err_clear = 1'b1;
    @(negedge clk);
    enc.err_clear = 1'b0;
    chk("errclr_err", 32'(enc.err_illegal), 0);
    chk("errclr_cnt", 32'(enc.illegal_cnt), 0);
    // illegal step landing while err_clear is held: the set must win
    enc.err_clear = 1'b1;
    enc.enc_a = 1'b1; enc.enc_b = 1'b1; ab = 2'b11;
    repeat (7) @(negedge clk);
    chk("setwins_err", 32'(enc.err_illegal), 1);
    chk("setwins_cnt", 32'(enc.illegal_cnt), 1);
    @(negedge clk);
    chk("setwins_next_err", 32'(enc.err_illegal), 0);
    enc.err_clear = 1'b0;
    repeat (10) @(negedge clk);
    step(1, 2, 20);
    chk("recover_pos", enc.actual_pos, 1);
    enc.clear_pos = 1'b1;
    @(negedge clk);
    enc.clear_pos = 1'b0;
    exp_pos = 0;
    step(1, 100, 8);
    chk("pre_idx_pos", enc.actual_pos, 100);
    chk("pre_idx_seen", 32'(enc.index_seen), 0);
    enc.index_clear_en = 1'b1;
    enc.enc_z = 1'b1;
    repeat (10) @(negedge clk);
    enc.enc_z = 1'b0;
    repeat (10) @(negedge clk);
    enc.index_clear_en = 1'b0;
    exp_pos = 0;
    chk("idx_pos", enc.actual_pos, 0);
    chk("idx_seen", 32'(enc.index_seen), 1);
    enc.clear_pos = 1'b1;
    step(1, 8, 8);
    chk("hold_clear_pos", enc.actual_pos, 0);
    enc.clear_pos = 1'b0;
    @(negedge clk);
    step(1, 3, 8);
    chk("premid_pos", enc.actual_pos, 3);
    drive_ab(nxt(1, ab), 3);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    q.delete();
    drive_ab(2'b00, 3);
    reset = 1'b0;
    exp_pos = 0;
    repeat (20) @(negedge clk);
    chk("post_reset_pos", enc.actual_pos, 0);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
